cv32e40p_register_file_mp: RTL and testbench

Parametrised multi-port integer/FP register file. It is the next generation of the core's latch register file and uses flip-flop storage.
- Port count, depth and width are configurable.
- Register 0 can be hard-wired to zero.
- A per-register busy scoreboard tracks outstanding long-latency writes (LSU, FPU, divider).
- It sits in the ID stage. Reads are combinational; writes come from the WB and APU writeback paths.

---
 rtl/cv32e40p_regfile_pkg.sv | 22 ++
 rtl/cv32e40p_regfile_scoreboard.sv | 53 +++++
 rtl/cv32e40p_register_file_mp.sv | 102 ++++++++++
 tb/tb_cv32e40p_register_file_mp.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_regfile_pkg.sv
// Shared types and helpers for the cv32e40p multi-port register file.
// onehot_decode works on addresses up to RF_MAX_ADDR_WIDTH bits; callers zero-extend and slice.
package cv32e40p_regfile_pkg;

    localparam int RF_ADDR_WIDTH     = 5;
    localparam int RF_DATA_WIDTH     = 32;
    localparam int RF_MAX_ADDR_WIDTH = 8;
    localparam int RF_MAX_WORDS      = 2 ** RF_MAX_ADDR_WIDTH;

    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;
    typedef logic [RF_MAX_WORDS-1:0]  rf_wordvec_t;

    function automatic rf_wordvec_t onehot_decode(input logic [RF_MAX_ADDR_WIDTH-1:0] addr,
                                                  input logic en);
        rf_wordvec_t v;
        v       = '0;
        v[addr] = en;
        return v;
    endfunction

endpackage

// File: rtl/cv32e40p_regfile_scoreboard.sv
// Per-word busy bits tracking outstanding long-latency writes.
// Update order: flush clears all, write ports clear their target, reserve sets last.
module cv32e40p_regfile_scoreboard
    import cv32e40p_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH     = RF_ADDR_WIDTH,
    parameter int NR_WRITE_PORTS = 2,
    parameter int ZERO_REG       = 1,
    localparam int NUM_WORDS     = 2 ** ADDR_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NR_WRITE_PORTS-1:0]                i_we,
    input  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] i_waddr,
    input  logic                                     i_rsv,
    input  logic [ADDR_WIDTH-1:0]                    i_rsv_addr,
    input  logic                                     i_flush,
    output logic [NUM_WORDS-1:0]                     o_busy_vec
);

    logic [NUM_WORDS-1:0] r_busy;
    logic [NUM_WORDS-1:0] w_busy_nxt;
    rf_wordvec_t          w_dec;

    always_comb begin
        w_busy_nxt = r_busy;
        w_dec      = '0;
        if (i_flush) begin
            w_busy_nxt = '0;
        end
        for (int p = 0; p < NR_WRITE_PORTS; p++) begin
            w_dec      = onehot_decode(RF_MAX_ADDR_WIDTH'(i_waddr[p]), i_we[p]);
            w_busy_nxt = w_busy_nxt & ~w_dec[NUM_WORDS-1:0];
        end
        // Reserve wins over same-cycle clears: it names the new producer.
        w_dec      = onehot_decode(RF_MAX_ADDR_WIDTH'(i_rsv_addr), i_rsv);
        w_busy_nxt = w_busy_nxt | w_dec[NUM_WORDS-1:0];
        if (ZERO_REG != 0) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy_vec = r_busy;

endmodule

// File: rtl/cv32e40p_register_file_mp.sv
// Multi-port flip-flop register file with busy scoreboard; reads are combinational.
// Optional macro CV32E40P_RF_BYPASS_EN forwards same-cycle write data to matching reads.
module cv32e40p_register_file_mp
    import cv32e40p_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH     = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = RF_DATA_WIDTH,
    parameter int NR_READ_PORTS  = 3,
    parameter int NR_WRITE_PORTS = 2,
    parameter int ZERO_REG       = 1,
    localparam int NUM_WORDS     = 2 ** ADDR_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0] raddr_i,
    output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] rdata_o,
    output logic [NR_READ_PORTS-1:0]                 rbusy_o,
    input  logic [NR_WRITE_PORTS-1:0]                we_i,
    input  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_i,
    input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
    input  logic                                     rsv_i,
    input  logic [ADDR_WIDTH-1:0]                    rsv_addr_i,
    input  logic                                     flush_i,
    output logic [NUM_WORDS-1:0]                     busy_vec_o
);

    logic [NR_WRITE_PORTS-1:0][NUM_WORDS-1:0] w_sel;
    logic [DATA_WIDTH-1:0]                    w_mem [NUM_WORDS];
    rf_wordvec_t                              w_dec;

    always_comb begin
        w_dec = '0;
        w_sel = '0;
        for (int p = 0; p < NR_WRITE_PORTS; p++) begin
            w_dec    = onehot_decode(RF_MAX_ADDR_WIDTH'(waddr_i[p]), we_i[p]);
            w_sel[p] = w_dec[NUM_WORDS-1:0];
        end
    end

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_word
        if (ZERO_REG != 0 && g == 0) begin : g_zero
            assign w_mem[g] = '0;
        end else begin : g_ff
            logic [DATA_WIDTH-1:0] r_word;
            logic [DATA_WIDTH-1:0] w_wdata;

            // Ascending scan: the highest-indexed port targeting this word wins.
            always_comb begin
                w_wdata = r_word;
                for (int p = 0; p < NR_WRITE_PORTS; p++) begin
                    if (w_sel[p][g]) begin
                        w_wdata = wdata_i[p];
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_word <= '0;
                end else begin
                    r_word <= w_wdata;
                end
            end

            assign w_mem[g] = r_word;
        end
    end

    cv32e40p_regfile_scoreboard #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .NR_WRITE_PORTS (NR_WRITE_PORTS),
        .ZERO_REG       (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_we       (we_i),
        .i_waddr    (waddr_i),
        .i_rsv      (rsv_i),
        .i_rsv_addr (rsv_addr_i),
        .i_flush    (flush_i),
        .o_busy_vec (busy_vec_o)
    );

    always_comb begin
        for (int r = 0; r < NR_READ_PORTS; r++) begin
            rdata_o[r] = w_mem[raddr_i[r]];
            rbusy_o[r] = busy_vec_o[raddr_i[r]];
`ifdef CV32E40P_RF_BYPASS_EN
            for (int p = 0; p < NR_WRITE_PORTS; p++) begin
                if (we_i[p] && (waddr_i[p] == raddr_i[r]) &&
                    !((ZERO_REG != 0) && (raddr_i[r] == '0))) begin
                    rdata_o[r] = wdata_i[p];
                    if (!(rsv_i && (rsv_addr_i == raddr_i[r]))) begin
                        rbusy_o[r] = 1'b0;
                    end
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_cv32e40p_register_file_mp.sv
// Bench for cv32e40p_register_file_mp: directed table, corner sequences and random traffic
// against an array-based reference model; a second instance runs with ZERO_REG=0.
module tb_cv32e40p_register_file_mp;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0][4:0]  raddr;
    logic [2:0][31:0] rdata_a, rdata_b;
    logic [2:0]       rbusy_a, rbusy_b;
    logic [1:0]       we;
    logic [1:0][4:0]  waddr;
    logic [1:0][31:0] wdata;
    logic             rsv;
    logic [4:0]       rsv_addr;
    logic             flush;
    logic [31:0]      bv_a, bv_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: index 0 models ZERO_REG=1, index 1 models ZERO_REG=0.
    logic [31:0] m_mem  [2][32];
    logic        m_busy [2][32];
    bit          m_zr   [2] = '{1'b1, 1'b0};

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        rsv;
        logic [4:0]  ra;
        logic        flush;
        logic [4:0]  rd_addr;
        logic [31:0] exp_rd;
        logic        exp_rbusy;
        logic [31:0] exp_bv;
    } vec_t;

    vec_t tbl [10];

    cv32e40p_register_file_mp #(.ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata_a), .rbusy_o(rbusy_a),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .rsv_i(rsv), .rsv_addr_i(rsv_addr),
        .flush_i(flush), .busy_vec_o(bv_a)
    );

    cv32e40p_register_file_mp #(.ZERO_REG(0)) dut_nz (
        .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .rsv_i(rsv), .rsv_addr_i(rsv_addr),
        .flush_i(flush), .busy_vec_o(bv_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 32; a++) begin
                m_mem[k][a]  = '0;
                m_busy[k][a] = 1'b0;
            end
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 2; w++)
                if (we[w] && !(m_zr[k] && waddr[w] == 0)) m_mem[k][waddr[w]] = wdata[w];
            if (flush)
                for (int a = 0; a < 32; a++) m_busy[k][a] = 1'b0;
            for (int w = 0; w < 2; w++)
                if (we[w]) m_busy[k][waddr[w]] = 1'b0;
            if (rsv && !(m_zr[k] && rsv_addr == 0)) m_busy[k][rsv_addr] = 1'b1;
        end
    endtask

    function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
        logic [31:0] v;
        v = m_mem[k][a];
`ifdef CV32E40P_RF_BYPASS_EN
        if (!(m_zr[k] && a == 0))
            for (int w = 0; w < 2; w++)
                if (we[w] && waddr[w] == a) v = wdata[w];
`endif
        return v;
    endfunction

    function automatic logic exp_busy(int k, logic [4:0] a);
        logic b;
        b = m_busy[k][a];
`ifdef CV32E40P_RF_BYPASS_EN
        if (!(m_zr[k] && a == 0) && !(rsv && rsv_addr == a))
            for (int w = 0; w < 2; w++)
                if (we[w] && waddr[w] == a) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic logic [31:0] model_bv(int k);
        logic [31:0] v;
        for (int a = 0; a < 32; a++) v[a] = m_busy[k][a];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_ctrl();
        we = '0; rsv = 1'b0; flush = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("%s rdata_a[%0d]", tag, r), rdata_a[r], exp_rd(0, raddr[r]));
            chk($sformatf("%s rdata_b[%0d]", tag, r), rdata_b[r], exp_rd(1, raddr[r]));
            chk($sformatf("%s rbusy_a[%0d]", tag, r), 32'(rbusy_a[r]), 32'(exp_busy(0, raddr[r])));
            chk($sformatf("%s rbusy_b[%0d]", tag, r), 32'(rbusy_b[r]), 32'(exp_busy(1, raddr[r])));
        end
        chk({tag, " busy_vec_a"}, bv_a, model_bv(0));
        chk({tag, " busy_vec_b"}, bv_b, model_bv(1));
    endtask

    initial begin
        rst = 1'b1; raddr = '0; waddr = '0; wdata = '0; rsv_addr = '0;
        idle_ctrl();
        model_reset();

        // we, wa0, wa1, wd0, wd1, rsv, rsv_addr, flush, read addr, exp rdata, exp rbusy, exp busy_vec
        tbl[0] = '{2'b01, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 5'd0,  1'b0, 5'd5,  32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1] = '{2'b11, 5'd7,  5'd7,  32'h11111111, 32'h22222222, 1'b0, 5'd0,  1'b0, 5'd7,  32'h22222222, 1'b0, 32'h0};
        tbl[2] = '{2'b01, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,        1'b1, 5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
        tbl[3] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd10, 1'b0, 5'd10, 32'h0,        1'b1, 32'h00000400};
        tbl[4] = '{2'b10, 5'd0,  5'd10, 32'h0,        32'h12345678, 1'b1, 5'd10, 1'b0, 5'd10, 32'h12345678, 1'b1, 32'h00000400};
        tbl[5] = '{2'b10, 5'd0,  5'd10, 32'h0,        32'hCAFEF00D, 1'b0, 5'd0,  1'b0, 5'd10, 32'hCAFEF00D, 1'b0, 32'h0};
        tbl[6] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  32'h0,        1'b1, 32'h00000008};
        tbl[7] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  1'b1, 5'd3,  32'h0,        1'b0, 32'h0};
        tbl[8] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd20, 1'b1, 5'd20, 32'h0,        1'b1, 32'h00100000};
        tbl[9] = '{2'b01, 5'd20, 5'd0,  32'h0BADF00D, 32'h0,        1'b0, 5'd0,  1'b0, 5'd20, 32'h0BADF00D, 1'b0, 32'h0};

        // Reset state
        raddr = {5'd3, 5'd2, 5'd1};
        tick(); tick();
        chk("reset rdata0", rdata_a[0], 32'h0);
        chk("reset busy_vec", bv_a, 32'h0);
        rst = 1'b0;
        #1;
        check_all("post-reset");

        // Directed table
        for (int i = 0; i < 10; i++) begin
            we = tbl[i].we; waddr = {tbl[i].wa1, tbl[i].wa0}; wdata = {tbl[i].wd1, tbl[i].wd0};
            rsv = tbl[i].rsv; rsv_addr = tbl[i].ra; flush = tbl[i].flush;
            raddr = {5'd0, tbl[i].rd_addr, tbl[i].rd_addr};
            tick();
            idle_ctrl();
            #1;
            chk($sformatf("tbl[%0d] rdata", i), rdata_a[0], tbl[i].exp_rd);
            chk($sformatf("tbl[%0d] rbusy", i), 32'(rbusy_a[0]), 32'(tbl[i].exp_rbusy));
            chk($sformatf("tbl[%0d] busy_vec", i), bv_a, tbl[i].exp_bv);
        end

        // ZERO_REG=0 instance keeps x0 and may reserve it
        raddr = '0;
        we = 2'b01; waddr = '0; wdata = {32'h0, 32'hFFFFFFFF}; rsv = 1'b1; rsv_addr = 5'd0;
        tick();
        idle_ctrl();
        #1;
        chk("zr0 x0 rdata", rdata_b[0], 32'hFFFFFFFF);
        chk("zr0 x0 busy", 32'(bv_b[0]), 32'h1);
        chk("zr1 x0 rdata", rdata_a[0], 32'h0);
        chk("zr1 x0 busy", 32'(bv_a[0]), 32'h0);

        // Asynchronous reset mid-test, with a write and reserve in the reset cycle
        raddr = {5'd0, 5'd5, 5'd5};
        #1;
        chk("pre-rst x5", rdata_a[0], 32'hDEADBEEF);
        we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'h12345678}; rsv = 1'b1; rsv_addr = 5'd5;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst x5 during", rdata_a[0], 32'h0);
        chk("rst busy_vec during", bv_a, 32'h0);
        tick();
        idle_ctrl();
        rst = 1'b0;
        #1;
        chk("rst x5 after", rdata_a[0], 32'h0);
        chk("rst busy_vec after", bv_a, 32'h0);
        chk("rst zr0 busy_vec after", bv_b, 32'h0);

        // Read-after-write latency on x12
        raddr = {5'd0, 5'd12, 5'd12};
        we = 2'b01; waddr = {5'd0, 5'd12}; wdata = {32'h0, 32'hA5A5A5A5};
        #1;
`ifdef CV32E40P_RF_BYPASS_EN
        chk("raw cycle N", rdata_a[0], 32'hA5A5A5A5);
`else
        chk("raw cycle N", rdata_a[0], 32'h0);
`endif
        chk("raw cycle N rbusy", 32'(rbusy_a[0]), 32'h0);
        tick();
        idle_ctrl();
        #1;
        chk("raw cycle N+1", rdata_a[0], 32'hA5A5A5A5);

        // Random traffic on a narrow address range to provoke collisions
        for (int i = 0; i < 400; i++) begin
            we       = 2'($urandom_range(0, 3));
            waddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wdata    = {32'($urandom), 32'($urandom)};
            rsv      = ($urandom_range(0, 2) == 0);
            rsv_addr = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 24) == 0);
            raddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            #1;
            check_all($sformatf("rand[%0d]", i));
            tick();
        end
        idle_ctrl();
        #1;
        check_all("rand final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
